rom_loader: RTL and testbench

//  Parametrised multi-region boot copier: streams byte-wide flash into 16-bit SDRAM words

---
 rtl/rom_loader.sv | 199 +++++++++++++++++++
 tb/tb_rom_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - multi-region flash-to-SDRAM boot copier with per-region address remapping
// Pairs of flash bytes become big-endian SDRAM words; console reset is released once every region is written.
module rom_loader #(
    parameter int NUM_REGIONS = 4,
    parameter int FL_AW       = 22,
    parameter int SD_AW       = 22,
    parameter int LEN_W       = 21,
    parameter int WAIT_CYCLES = 3,
    parameter bit AUTO_START  = 1'b1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic [NUM_REGIONS*FL_AW-1:0] REG_SRC,
    input  logic [NUM_REGIONS*SD_AW-1:0] REG_DST,
    input  logic [NUM_REGIONS*LEN_W-1:0] REG_LEN,
    input  logic [NUM_REGIONS*2-1:0]     REG_MODE,
    input  logic [FL_AW-1:0]             RUN_ADDR,
    output logic [FL_AW-1:0]             FL_ADDR,
    input  logic [7:0]                   FL_DQ,
    output logic                         WR_REQ,
    input  logic                         WR_ACK,
    output logic [SD_AW-1:0]             SD_ADDR,
    output logic [15:0]                  SD_DATA,
    output logic                         BUSY,
    output logic                         DONE,
    output logic [2:0]                   REGION,
    output logic                         nRESET
);

    localparam int WAIT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HI,
        S_LO,
        S_WR,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [2:0]         region_q;
    logic [FL_AW-1:0]   src_q;
    logic [SD_AW-1:0]   dst_q;
    logic [LEN_W-1:0]   len_q;
    logic [1:0]         mode_q;
    logic [FL_AW-1:0]   off_q;
    logic [LEN_W-1:0]   word_q;
    logic [WAIT_W-1:0]  wait_q;
    logic               wr_req_q;
    logic [SD_AW-1:0]   sd_addr_q;
    logic [15:0]        sd_data_q;
    logic               busy_q;
    logic               done_q;
    logic               nreset_q;

    logic [FL_AW-1:0]   src_sel;
    logic [SD_AW-1:0]   dst_sel;
    logic [LEN_W-1:0]   len_sel;
    logic [1:0]         mode_sel;
    logic [FL_AW-1:0]   map_off;
    logic [FL_AW-1:0]   len_fl;
    logic               sample_now;

    always_comb begin
        src_sel  = '0;
        dst_sel  = '0;
        len_sel  = '0;
        mode_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (region_q == 3'(i)) begin
                src_sel  = REG_SRC[i*FL_AW +: FL_AW];
                dst_sel  = REG_DST[i*SD_AW +: SD_AW];
                len_sel  = REG_LEN[i*LEN_W +: LEN_W];
                mode_sel = REG_MODE[i*2 +: 2];
            end
        end
    end

    // C-ROM interleave: bit 1 of the offset selects the second half, bit 0 the byte within a pair
    assign len_fl = FL_AW'(len_q);

    always_comb begin
        map_off = off_q;
        case (mode_q)
            2'd1:    map_off = {off_q[FL_AW-1:4], off_q[0], off_q[3:1]};
            2'd2:    map_off = {1'b0, off_q[FL_AW-1:2], off_q[0]} + (off_q[1] ? len_fl : '0);
            default: map_off = off_q;
        endcase
    end

    assign FL_ADDR    = busy_q ? (src_q + map_off) : RUN_ADDR;
    assign sample_now = (wait_q == WAIT_W'(WAIT_CYCLES));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            region_q  <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            mode_q    <= '0;
            off_q     <= '0;
            word_q    <= '0;
            wait_q    <= '0;
            wr_req_q  <= 1'b0;
            sd_addr_q <= '0;
            sd_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nreset_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START || AUTO_START) begin
                        state_q  <= S_SETUP;
                        region_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                S_SETUP: begin
                    src_q   <= src_sel;
                    dst_q   <= dst_sel;
                    len_q   <= len_sel;
                    mode_q  <= mode_sel;
                    off_q   <= '0;
                    word_q  <= '0;
                    wait_q  <= '0;
                    state_q <= (len_sel == '0) ? S_NEXT : S_HI;
                end
                S_HI: begin
                    if (sample_now) begin
                        sd_data_q[15:8] <= FL_DQ;
                        off_q           <= off_q + FL_AW'(1);
                        wait_q          <= '0;
                        state_q         <= S_LO;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_LO: begin
                    if (sample_now) begin
                        sd_data_q[7:0] <= FL_DQ;
                        off_q          <= off_q + FL_AW'(1);
                        wait_q         <= '0;
                        wr_req_q       <= 1'b1;
                        sd_addr_q      <= dst_q + SD_AW'(word_q);
                        state_q        <= S_WR;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_WR: begin
                    if (WR_ACK) begin
                        wr_req_q <= 1'b0;
                        if (word_q == len_q - LEN_W'(1)) begin
                            state_q <= S_NEXT;
                        end else begin
                            word_q  <= word_q + LEN_W'(1);
                            state_q <= S_HI;
                        end
                    end
                end
                S_NEXT: begin
                    if (region_q == 3'(NUM_REGIONS - 1)) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        nreset_q <= 1'b1;
                    end else begin
                        region_q <= region_q + 3'd1;
                        state_q  <= S_SETUP;
                    end
                end
                S_DONE: begin
                    if (START) begin
                        state_q  <= S_SETUP;
                        region_q <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        nreset_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign WR_REQ  = wr_req_q;
    assign SD_ADDR = sd_addr_q;
    assign SD_DATA = sd_data_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign REGION  = region_q;
    assign nRESET  = nreset_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - directed self-checking bench for rom_loader
// Flash is a byte array behind FL_ADDR; the SDRAM side acks each write after a chosen delay.
module tb_rom_loader;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            START = 1'b0;
    logic [87:0]     REG_SRC = '0;
    logic [87:0]     REG_DST = '0;
    logic [83:0]     REG_LEN = '0;
    logic [7:0]      REG_MODE = '0;
    logic [21:0]     RUN_ADDR = 22'h2A5A5A;
    logic [21:0]     FL_ADDR;
    logic [7:0]      FL_DQ;
    logic            WR_REQ;
    logic            WR_ACK = 1'b0;
    logic [21:0]     SD_ADDR;
    logic [15:0]     SD_DATA;
    logic            BUSY;
    logic            DONE;
    logic [2:0]      REGION;
    logic            nRESET;

    logic [7:0]      flash [0:4095];
    logic [21:0]     cap_addr [0:15];
    logic [15:0]     cap_data [0:15];
    logic [2:0]      cap_reg  [0:15];
    int              total = 0;
    int              bad = 0;

    assign FL_DQ = flash[FL_ADDR[11:0]];

    rom_loader #(
        .NUM_REGIONS(4),
        .FL_AW(22),
        .SD_AW(22),
        .LEN_W(21),
        .WAIT_CYCLES(3),
        .AUTO_START(1'b1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .START(START),
        .REG_SRC(REG_SRC),
        .REG_DST(REG_DST),
        .REG_LEN(REG_LEN),
        .REG_MODE(REG_MODE),
        .RUN_ADDR(RUN_ADDR),
        .FL_ADDR(FL_ADDR),
        .FL_DQ(FL_DQ),
        .WR_REQ(WR_REQ),
        .WR_ACK(WR_ACK),
        .SD_ADDR(SD_ADDR),
        .SD_DATA(SD_DATA),
        .BUSY(BUSY),
        .DONE(DONE),
        .REGION(REGION),
        .nRESET(nRESET)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    task automatic clear_table();
        REG_SRC = '0;
        REG_DST = '0;
        REG_LEN = '0;
        REG_MODE = '0;
    endtask

    task automatic set_region(input int r, input logic [21:0] src, input logic [21:0] dst,
                              input logic [20:0] len, input logic [1:0] mode);
        REG_SRC[r*22 +: 22] = src;
        REG_DST[r*22 +: 22] = dst;
        REG_LEN[r*21 +: 21] = len;
        REG_MODE[r*2 +: 2]  = mode;
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Captures n writes; checks address/data stay put while the ack is withheld.
    task automatic collect(input int n, input int ack_dly, input int budget);
        int got = 0;
        int held = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge CLK);
            cyc++;
            WR_ACK = 1'b0;
            if (WR_REQ === 1'b1) begin
                if (held == 0) begin
                    cap_addr[got] = SD_ADDR;
                    cap_data[got] = SD_DATA;
                    cap_reg[got]  = REGION;
                end else begin
                    total++;
                    if (SD_ADDR !== cap_addr[got] || SD_DATA !== cap_data[got]) begin
                        bad++;
                        $display("FAIL hold_stable word %0d: addr=%h data=%h, required addr=%h data=%h",
                                 got, SD_ADDR, SD_DATA, cap_addr[got], cap_data[got]);
                    end
                end
                if (held == ack_dly) begin
                    WR_ACK = 1'b1;
                    got++;
                    held = 0;
                end else begin
                    held++;
                end
            end
        end
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL collect_timeout: got %0d words, required %0d", got, n);
        end
        @(negedge CLK);
        WR_ACK = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int cyc = 0;
        int extra = 0;
        while (DONE !== 1'b1 && cyc < budget) begin
            @(negedge CLK);
            cyc++;
            if (WR_REQ === 1'b1) extra++;
        end
        total++;
        if (DONE !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout: DONE=%b after %0d cycles, required 1", DONE, cyc);
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL extra_write: %0d WR_REQ cycles after last word, required 0", extra);
        end
    endtask

    task automatic check_word(input string name, input int k, input logic [21:0] ea, input logic [15:0] ed);
        total++;
        if (cap_addr[k] !== ea || cap_data[k] !== ed) begin
            bad++;
            $display("FAIL %s word %0d: addr=%h data=%h, required addr=%h data=%h",
                     name, k, cap_addr[k], cap_data[k], ea, ed);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < 4096; i++) flash[i] = i[7:0];
        clear_table();
        set_region(0, 22'h000100, 22'h380000, 21'd2, 2'd0);
        repeat (3) @(negedge CLK);
        total++; if (WR_REQ !== 1'b0) begin bad++; $display("FAIL reset_wr_req: got %b, required 0", WR_REQ); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", BUSY); end
        total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done: got %b, required 0", DONE); end
        total++; if (nRESET !== 1'b0) begin bad++; $display("FAIL reset_nreset: got %b, required 0", nRESET); end
        total++; if (REGION !== 3'd0) begin bad++; $display("FAIL reset_region: got %0d, required 0", REGION); end
        total++; if (SD_ADDR !== 22'h0) begin bad++; $display("FAIL reset_sd_addr: got %h, required 0", SD_ADDR); end
        total++; if (SD_DATA !== 16'h0) begin bad++; $display("FAIL reset_sd_data: got %h, required 0", SD_DATA); end
        total++; if (FL_ADDR !== 22'h2A5A5A) begin bad++; $display("FAIL reset_fl_addr: got %h, required 2a5a5a", FL_ADDR); end
    endtask

    task automatic test_linear();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL linear_busy: got %b, required 1", BUSY); end
        collect(2, 0, 200);
        check_word("linear", 0, 22'h380000, 16'h0001);
        check_word("linear", 1, 22'h380001, 16'h0203);
        wait_done(100);
        total++; if (nRESET !== 1'b1) begin bad++; $display("FAIL linear_nreset: got %b, required 1", nRESET); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL linear_busy_end: got %b, required 0", BUSY); end
        total++; if (REGION !== 3'd3) begin bad++; $display("FAIL linear_region_end: got %0d, required 3", REGION); end
        total++; if (FL_ADDR !== 22'h2A5A5A) begin bad++; $display("FAIL linear_run_addr: got %h, required 2a5a5a", FL_ADDR); end
    endtask

    task automatic test_swizzle();
        logic [15:0] exp_sw [0:7] = '{16'h0008, 16'h0109, 16'h020A, 16'h030B,
                                      16'h040C, 16'h050D, 16'h060E, 16'h070F};
        clear_table();
        set_region(0, 22'h000000, 22'h000010, 21'd8, 2'd1);
        pulse_start();
        total++; if (DONE !== 1'b0) begin bad++; $display("FAIL restart_done: got %b, required 0", DONE); end
        total++; if (nRESET !== 1'b0) begin bad++; $display("FAIL restart_nreset: got %b, required 0", nRESET); end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL restart_busy: got %b, required 1", BUSY); end
        collect(8, 0, 400);
        for (int k = 0; k < 8; k++) check_word("swizzle", k, 22'h000010 + 22'(k), exp_sw[k]);
        wait_done(100);
    endtask

    task automatic test_interleave();
        logic [21:0] a0;
        logic [15:0] d0;
        for (int i = 0; i < 4; i++) begin
            flash[i]     = 8'hA0 + 8'(i);
            flash[i + 4] = 8'hB0 + 8'(i);
        end
        clear_table();
        set_region(0, 22'h000000, 22'h000200, 21'd4, 2'd2);
        pulse_start();
        collect(1, 1, 100);
        a0 = cap_addr[0];
        d0 = cap_data[0];
        pulse_start();
        collect(3, 1, 300);
        total++;
        if (a0 !== 22'h000200 || d0 !== 16'hA0A1) begin
            bad++;
            $display("FAIL interleave word 0: addr=%h data=%h, required addr=000200 data=a0a1", a0, d0);
        end
        check_word("interleave", 0, 22'h000201, 16'hB0B1);
        check_word("interleave", 1, 22'h000202, 16'hA2A3);
        check_word("interleave", 2, 22'h000203, 16'hB2B3);
        wait_done(100);
    endtask

    task automatic test_ack_delay();
        clear_table();
        set_region(1, 22'h000100, 22'h004000, 21'd3, 2'd0);
        pulse_start();
        collect(3, 5, 400);
        check_word("ack_delay", 0, 22'h004000, 16'h0001);
        check_word("ack_delay", 1, 22'h004001, 16'h0203);
        check_word("ack_delay", 2, 22'h004002, 16'h0405);
        total++; if (cap_reg[2] !== 3'd1) begin bad++; $display("FAIL ack_delay_region: got %0d, required 1", cap_reg[2]); end
        wait_done(100);
    endtask

    task automatic test_skip();
        clear_table();
        set_region(0, 22'h000300, 22'h001000, 21'd1, 2'd0);
        set_region(2, 22'h000310, 22'h002000, 21'd1, 2'd3);
        pulse_start();
        collect(2, 0, 300);
        total++; if (DONE !== 1'b0) begin bad++; $display("FAIL skip_done_early: got %b, required 0", DONE); end
        total++; if (nRESET !== 1'b0) begin bad++; $display("FAIL skip_nreset_early: got %b, required 0", nRESET); end
        check_word("skip", 0, 22'h001000, 16'h0001);
        check_word("skip", 1, 22'h002000, 16'h1011);
        total++; if (cap_reg[0] !== 3'd0) begin bad++; $display("FAIL skip_region0: got %0d, required 0", cap_reg[0]); end
        total++; if (cap_reg[1] !== 3'd2) begin bad++; $display("FAIL skip_region1: got %0d, required 2", cap_reg[1]); end
        wait_done(100);
        total++; if (nRESET !== 1'b1) begin bad++; $display("FAIL skip_nreset: got %b, required 1", nRESET); end
    endtask

    task automatic test_rst_mid();
        int cyc = 0;
        clear_table();
        set_region(0, 22'h000100, 22'h380000, 21'd2, 2'd0);
        pulse_start();
        while (WR_REQ !== 1'b1 && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        total++; if (WR_REQ !== 1'b1) begin bad++; $display("FAIL rst_mid_reach_wr: got %b, required 1", WR_REQ); end
        #2;
        RST = 1'b1;
        #1;
        total++; if (WR_REQ !== 1'b0) begin bad++; $display("FAIL rst_mid_wr_req: got %b, required 0", WR_REQ); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b, required 0", BUSY); end
        @(negedge CLK);
        RST = 1'b0;
        collect(2, 0, 200);
        check_word("rst_restart", 0, 22'h380000, 16'h0001);
        check_word("rst_restart", 1, 22'h380001, 16'h0203);
        wait_done(100);
    endtask

    initial begin
        test_reset();
        test_linear();
        test_swizzle();
        test_interleave();
        test_ack_delay();
        test_skip();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
